// File: rtl/apb_mem_arbiter_if.sv
// Bundle of the two requester ports plus the APB bus of the shared memory slave.
// The master modport is the arbiter's view; slave is the requesters plus memory.
interface apb_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic              err0;
  logic              err1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pvalid;
  logic              busy;

  modport master (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, prdata, pvalid,
    output ack0, ack1, err0, err1, rdata0, rdata1,
           psel, penable, pwrite, paddr, pwdata, busy
  );

  modport slave (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, prdata, pvalid,
    input  ack0, ack1, err0, err1, rdata0, rdata1,
           psel, penable, pwrite, paddr, pwdata, busy
  );
endinterface

// File: rtl/apb_mem_arbiter.sv
// Two-port APB arbiter sharing one APB memory slave between fetch (port 0) and data (port 1).
// Define APB_ARB_RR_EN for round-robin on simultaneous requests; otherwise port 0 has fixed priority.
module apb_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  apb_mem_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RWAIT,
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              gnt_q;
  logic              last_gnt_q;
  logic              we_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              any_req;
  logic              tie_pick;
  logic              win;

  logic psel_c;
  logic penable_c;
  logic pwrite_c;
  logic busy_c;
  logic ack0_c;
  logic ack1_c;
  logic err0_c;
  logic err1_c;

  assign any_req = bus.req0 | bus.req1;

`ifdef APB_ARB_RR_EN
  assign tie_pick = ~last_gnt_q;
`else
  // Fixed priority: ties always go to port 0; last_gnt is tracked but does not steer.
  assign tie_pick = last_gnt_q & 1'b0;
`endif

  always_comb begin
    win = 1'b0;
    if (bus.req0 && bus.req1) begin
      win = tie_pick;
    end else begin
      win = ~bus.req0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = we_q ? DONE : RWAIT;
      RWAIT:   if (bus.pvalid || (cnt_q == TMO_LAST)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes and completion pulses decode purely from the state register.
  always_comb begin
    psel_c    = 1'b0;
    penable_c = 1'b0;
    pwrite_c  = 1'b0;
    busy_c    = (state_q != IDLE);
    ack0_c    = 1'b0;
    ack1_c    = 1'b0;
    err0_c    = 1'b0;
    err1_c    = 1'b0;
    case (state_q)
      SETUP: begin
        psel_c   = 1'b1;
        pwrite_c = we_q;
      end
      ACCESS: begin
        psel_c    = 1'b1;
        penable_c = 1'b1;
        pwrite_c  = we_q;
      end
      DONE: begin
        ack0_c = ~gnt_q;
        ack1_c = gnt_q;
        err0_c = ~gnt_q & err_q;
        err1_c = gnt_q & err_q;
      end
      default: ;
    endcase
  end

  // Request capture, read-data return and timeout bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q    <= win;
            we_q     <= win ? bus.we1    : bus.we0;
            paddr_q  <= win ? bus.addr1  : bus.addr0;
            pwdata_q <= win ? bus.wdata1 : bus.wdata0;
            err_q    <= 1'b0;
          end
        end
        ACCESS: begin
          cnt_q <= '0;
        end
        RWAIT: begin
          if (bus.pvalid) begin
            if (gnt_q) begin
              rdata1_q <= bus.prdata;
            end else begin
              rdata0_q <= bus.prdata;
            end
            err_q <= 1'b0;
          end else if (cnt_q == TMO_LAST) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          last_gnt_q <= gnt_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.psel    = psel_c;
  assign bus.penable = penable_c;
  assign bus.pwrite  = pwrite_c;
  assign bus.busy    = busy_c;
  assign bus.ack0    = ack0_c;
  assign bus.ack1    = ack1_c;
  assign bus.err0    = err0_c;
  assign bus.err1    = err1_c;
  assign bus.paddr   = paddr_q;
  assign bus.pwdata  = pwdata_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;

endmodule
